// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the MiniCPU decoder/writeback
// and the sequential ALU. The requester side (decoder + writeback) uses the
// master modport; the ALU uses the slave modport.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_carry;
  logic             flag_ov;
  logic             flag_zero;
  logic             flag_err;

  modport master (
    output in_valid, op, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, flag_carry, flag_ov, flag_zero, flag_err
  );

  modport slave (
    input  in_valid, op, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, flag_carry, flag_ov, flag_zero, flag_err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Single-cycle ADD/SUB/AND/OR/COMP, iterative
// one-bit-per-cycle SHL/SHR and shift-add MUL. Result and flags are registered
// and held in DONE until the consumer takes them.
//
// Optional feature: define ALU_SEQ_MUL_EN to build the iterative multiplier.
// Without it, opcode 6 completes at once with result 0 and flag_err set.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; in_ready high
// EXEC  | iterating a shift (n cycles) or a multiply (WIDTH cycles)
// DONE  | result/flags valid and frozen until out_ready
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam int               CW     = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] W_OPND = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    W_CNT  = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_TC = CW'(1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_COMP = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_nxt;
  logic [2:0]       op_q, op_nxt;
  // shift operand for SHL/SHR, multiplier for MUL
  logic [WIDTH-1:0] work_q, work_nxt;
  // iterations left; the last one is at terminal count 1
  logic [CW-1:0]    cnt_q, cnt_nxt;
  // sticky: a one has been shifted out of the top during SHL
  logic             shl_ov_q, shl_ov_nxt;

  logic [WIDTH-1:0] result_q, result_nxt;
  logic             carry_q, carry_nxt;
  logic             ov_q, ov_nxt;
  logic             zero_q, zero_nxt;
  logic             err_q, err_nxt;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_nxt;
  logic [2*WIDTH-1:0] mcand_q, mcand_nxt;
  logic [2*WIDTH-1:0] acc_step;
`endif

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             a_gt_b;
  logic [CW-1:0]    shift_n;
  logic [WIDTH-1:0] shift_step;

  assign add_sum  = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
  assign sub_diff = bus.operand_a - bus.operand_b;
  assign a_lt_b   = (bus.operand_a < bus.operand_b);
  assign a_eq_b   = (bus.operand_a == bus.operand_b);
  assign a_gt_b   = (bus.operand_a > bus.operand_b);

  // shift amounts beyond the word width all produce the same result, so clamp
  assign shift_n  = (bus.operand_b >= W_OPND) ? W_CNT : bus.operand_b[CW-1:0];

  assign shift_step = (op_q == OP_SHL) ? (work_q << 1) : (work_q >> 1);

`ifdef ALU_SEQ_MUL_EN
  assign acc_step = work_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and datapath update: accept, iterate, complete, release.
  always_comb begin
    state_nxt  = state_q;
    op_nxt     = op_q;
    work_nxt   = work_q;
    cnt_nxt    = cnt_q;
    shl_ov_nxt = shl_ov_q;
    result_nxt = result_q;
    carry_nxt  = carry_q;
    ov_nxt     = ov_q;
    zero_nxt   = zero_q;
    err_nxt    = err_q;
`ifdef ALU_SEQ_MUL_EN
    acc_nxt    = acc_q;
    mcand_nxt  = mcand_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_nxt    = bus.op;
          carry_nxt = 1'b0;
          ov_nxt    = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = DONE;
          case (bus.op)
            OP_ADD: begin
              result_nxt = add_sum[WIDTH-1:0];
              carry_nxt  = add_sum[WIDTH];
              ov_nxt     = add_sum[WIDTH];
            end
            OP_SUB: begin
              result_nxt = sub_diff;
              carry_nxt  = a_lt_b;
              ov_nxt     = a_lt_b;
            end
            OP_AND: result_nxt = bus.operand_a & bus.operand_b;
            OP_OR:  result_nxt = bus.operand_a | bus.operand_b;
            OP_COMP: result_nxt = {{(WIDTH-3){1'b0}}, a_gt_b, a_eq_b, a_lt_b};
            OP_SHL, OP_SHR: begin
              if (shift_n == '0) begin
                result_nxt = bus.operand_a;
              end else begin
                work_nxt   = bus.operand_a;
                cnt_nxt    = shift_n;
                shl_ov_nxt = 1'b0;
                state_nxt  = EXEC;
              end
            end
            OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
              acc_nxt   = '0;
              mcand_nxt = {{WIDTH{1'b0}}, bus.operand_a};
              work_nxt  = bus.operand_b;
              cnt_nxt   = W_CNT;
              state_nxt = EXEC;
`else
              result_nxt = '0;
              err_nxt    = 1'b1;
`endif
            end
            default: result_nxt = '0;
          endcase
        end
      end

      EXEC: begin
        cnt_nxt = cnt_q - CNT_TC;
        if (op_q == OP_MUL) begin
`ifdef ALU_SEQ_MUL_EN
          acc_nxt   = acc_step;
          mcand_nxt = mcand_q << 1;
          work_nxt  = work_q >> 1;
          if (cnt_q == CNT_TC) begin
            result_nxt = acc_step[WIDTH-1:0];
            ov_nxt     = |acc_step[2*WIDTH-1:WIDTH];
            state_nxt  = DONE;
          end
`else
          state_nxt = IDLE;
`endif
        end else begin
          work_nxt   = shift_step;
          shl_ov_nxt = shl_ov_q | ((op_q == OP_SHL) & work_q[WIDTH-1]);
          if (cnt_q == CNT_TC) begin
            result_nxt = shift_step;
            ov_nxt     = shl_ov_nxt;
            state_nxt  = DONE;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // zero flag follows whatever result is being committed on entry to DONE
    if ((state_q != DONE) && (state_nxt == DONE)) begin
      zero_nxt = (result_nxt == '0);
    end
  end

  // Datapath and output registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      shl_ov_q <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ov_q     <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
`endif
    end else begin
      op_q     <= op_nxt;
      work_q   <= work_nxt;
      cnt_q    <= cnt_nxt;
      shl_ov_q <= shl_ov_nxt;
      result_q <= result_nxt;
      carry_q  <= carry_nxt;
      ov_q     <= ov_nxt;
      zero_q   <= zero_nxt;
      err_q    <= err_nxt;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_nxt;
`endif
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.result     = result_q;
  assign bus.flag_carry = carry_q;
  assign bus.flag_ov    = ov_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq at WIDTH=8 with a cycle-level
// reference model and literal expectations per vector.
module tb_alu_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected outcome of one operation from plain arithmetic.
  task automatic compute(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic v,
                         output logic z, output logic e, output int lat);
    logic [63:0] wide;
    int n;
    c = 1'b0; v = 1'b0; e = 1'b0; lat = 1; r = '0;
    n = (int'(b) > W) ? W : int'(b);
    case (o)
      3'd0: begin wide = 64'(a) + 64'(b); r = wide[W-1:0]; c = wide[W]; v = c; end
      3'd1: begin r = a - b; c = (a < b); v = c; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin wide = 64'(a) << n; r = wide[W-1:0]; v = ((wide >> W) != 0); lat = 1 + n; end
      3'd5: begin r = a >> n; lat = 1 + n; end
      3'd6: begin
`ifdef ALU_SEQ_MUL_EN
        wide = 64'(a) * 64'(b); r = wide[W-1:0]; v = ((wide >> W) != 0); lat = 1 + W;
`else
        r = '0; e = 1'b1;
`endif
      end
      default: r = {5'd0, a > b, a == b, a < b};
    endcase
    z = (r == '0);
  endtask

  // Reference model: 0 idle, 1 computing, 2 result presented.
  int           m_state = 0;
  int           m_left = 0;
  logic [W-1:0] m_res = '0;
  logic         m_c = 1'b0, m_v = 1'b0, m_z = 1'b0, m_e = 1'b0;

  always @(posedge clk) begin
    int lat;
    if (rst) begin
      m_state = 0; m_res = '0; m_c = 1'b0; m_v = 1'b0; m_z = 1'b0; m_e = 1'b0;
    end else begin
      case (m_state)
        0: if (bus.in_valid) begin
          compute(bus.op, bus.operand_a, bus.operand_b, m_res, m_c, m_v, m_z, m_e, lat);
          if (lat == 1) m_state = 2;
          else begin m_state = 1; m_left = lat - 1; end
        end
        1: begin m_left--; if (m_left == 0) m_state = 2; end
        default: if (bus.out_ready) m_state = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc in_ready", 32'(bus.in_ready), 32'(m_state == 0));
      check("cyc out_valid", 32'(bus.out_valid), 32'(m_state == 2));
      if (m_state == 2) begin
        check("cyc result", 32'(bus.result), 32'(m_res));
        check("cyc flags", 32'({bus.flag_carry, bus.flag_ov, bus.flag_zero, bus.flag_err}),
              32'({m_c, m_v, m_z, m_e}));
      end
    end
  end

  // One request with literal expectations; flags ordered {carry, ov, zero, err}.
  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic [3:0] ef,
                        input int elat);
    int lat;
    bus.in_valid = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(elat));
    check({name, " result"}, 32'(bus.result), 32'(er));
    check({name, " flags"}, 32'({bus.flag_carry, bus.flag_ov, bus.flag_zero, bus.flag_err}),
          32'(ef));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset flags", 32'({bus.flag_carry, bus.flag_ov, bus.flag_zero, bus.flag_err}), 32'd0);
    @(posedge clk); #1;

    run_op("add_carry", 3'd0, 8'hF0, 8'h20, 8'h10, 4'b1100, 1);
    run_op("add_wrap0", 3'd0, 8'hFF, 8'h01, 8'h00, 4'b1110, 1);
    run_op("sub_eq",    3'd1, 8'h05, 8'h05, 8'h00, 4'b0010, 1);
    run_op("sub_borrow",3'd1, 8'h03, 8'h05, 8'hFE, 4'b1100, 1);
    run_op("and",       3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1);
    run_op("or_zero",   3'd3, 8'h00, 8'h00, 8'h00, 4'b0010, 1);
    run_op("shl3",      3'd4, 8'h81, 8'd3,  8'h08, 4'b0100, 4);
    run_op("shl0",      3'd4, 8'h81, 8'd0,  8'h81, 4'b0000, 1);
    run_op("shl7",      3'd4, 8'h01, 8'd7,  8'h80, 4'b0000, 8);
    run_op("shr_clamp", 3'd5, 8'hFF, 8'd9,  8'h00, 4'b0010, 9);
    run_op("shr7",      3'd5, 8'h80, 8'd7,  8'h01, 4'b0000, 8);
`ifdef ALU_SEQ_MUL_EN
    run_op("mul_ov",    3'd6, 8'h12, 8'h10, 8'h20, 4'b0100, 9);
    run_op("mul_fit",   3'd6, 8'h0F, 8'h0F, 8'hE1, 4'b0000, 9);
`else
    run_op("mul_off",   3'd6, 8'h12, 8'h10, 8'h00, 4'b0011, 1);
    run_op("mul_off2",  3'd6, 8'h0F, 8'h0F, 8'h00, 4'b0011, 1);
`endif
    run_op("comp_lt",   3'd7, 8'd5,  8'd9,  8'h01, 4'b0000, 1);
    run_op("comp_eq",   3'd7, 8'd9,  8'd9,  8'h02, 4'b0000, 1);
    run_op("comp_gt",   3'd7, 8'hC8, 8'h03, 8'h04, 4'b0000, 1);

    // backpressure: result held, new request ignored while DONE
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = 3'd0; bus.operand_a = 8'h10; bus.operand_b = 8'h22;
    @(posedge clk); #1;
    bus.op = 3'd1; bus.operand_a = 8'h09; bus.operand_b = 8'h01;
    repeat (5) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp result", 32'(bus.result), 32'h32);
    check("bp flags", 32'({bus.flag_carry, bus.flag_ov, bus.flag_zero, bus.flag_err}), 32'd0);
    check("bp out_valid", 32'(bus.out_valid), 32'd1);
    check("bp in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp release in_ready", 32'(bus.in_ready), 32'd1);
    check("bp release out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // reset three cycles into a multiply
    bus.in_valid = 1'b1; bus.op = 3'd6; bus.operand_a = 8'h12; bus.operand_b = 8'h10;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst result", 32'(bus.result), 32'd0);
    repeat (15) @(posedge clk);
    #1;

    run_op("after_rst_add", 3'd0, 8'h01, 8'h02, 8'h03, 4'b0000, 1);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
